// File: rtl/phase_timer.sv
// Multi-phase countdown timer: each phase counts its table duration down to zero,
// then advances, optionally wrapping back to phase 0 after the final phase.
module phase_timer #(
  parameter int CNT_W       = 7,
  parameter int NUM_PH      = 3,
  parameter int PH_W        = 2,
  parameter int AUTO_RELOAD = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    start,
  input  logic                    hold,
  input  logic [NUM_PH*CNT_W-1:0] dur_tbl,
  output logic [CNT_W-1:0]        count,
  output logic [PH_W-1:0]         phase,
  output logic                    busy,
  output logic                    last,
  output logic                    pre_last,
  output logic                    phase_done,
  output logic                    cycle_done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam int              TBL_N   = 1 << PH_W;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PH - 1);

  state_t          state;
  logic [PH_W-1:0] next_ph;
  logic [CNT_W-1:0] dur [TBL_N];

  // Table padded to a power of two so any phase index selects a defined entry.
  for (genvar k = 0; k < TBL_N; k++) begin : g_dur
    if (k < NUM_PH) begin : g_used
      assign dur[k] = dur_tbl[k*CNT_W +: CNT_W];
    end else begin : g_pad
      assign dur[k] = '0;
    end
  end

  assign next_ph = phase + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      phase      <= '0;
      phase_done <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      cycle_done <= 1'b0;
      if (start) begin
        state <= RUN;
        phase <= '0;
        count <= dur[0];
      end else begin
        case (state)
          RUN: begin
            if (hold) begin
              state <= PAUSE;
            end else if (en) begin
              if (count != '0) begin
                count <= count - 1'b1;
              end else if (phase != LAST_PH) begin
                phase      <= next_ph;
                count      <= dur[next_ph];
                phase_done <= 1'b1;
              end else begin
                phase_done <= 1'b1;
                cycle_done <= 1'b1;
                if (AUTO_RELOAD != 0) begin
                  phase <= '0;
                  count <= dur[0];
                end else begin
                  state <= IDLE;
                  count <= '0;
                end
              end
            end
          end
          // Release only returns to RUN; the tick on that edge is not counted.
          PAUSE: begin
            if (!hold) state <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy     = (state != IDLE);
  assign last     = busy && (count == '0);
  assign pre_last = busy && (count == CNT_W'(1));

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 7, meaning counter and duration width in bits.
REQ-002 The block SHALL have parameter NUM_PH, default 3, meaning number of phases per cycle (range 2..16).
REQ-003 The block SHALL have parameter PH_W, default 2, meaning phase index width, with PH_W >= clog2(NUM_PH).
REQ-004 The block SHALL have parameter AUTO_RELOAD, default 1, meaning 1 = restart at phase 0 after the last phase, 0 = stop in IDLE.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit, the count tick enable (e.g. 1 Hz strobe).
REQ-008 The block SHALL have port start, input, 1 bit, which loads phase 0 and runs.
REQ-009 The block SHALL have port hold, input, 1 bit, which pauses counting while high.
REQ-010 The block SHALL have port dur_tbl, input, NUM_PH*CNT_W bits, the per-phase duration table; phase k occupies bits [k*CNT_W +: CNT_W].
REQ-011 The block SHALL have port count, output, CNT_W bits, the current remaining count (registered).
REQ-012 The block SHALL have port phase, output, PH_W bits, the current phase index (registered).
REQ-013 The block SHALL have port busy, output, 1 bit, high in RUN or PAUSE.
REQ-014 The block SHALL have port last, output, 1 bit, equal to busy and count==0.
REQ-015 The block SHALL have port pre_last, output, 1 bit, equal to busy and count==1.
REQ-016 The block SHALL have port phase_done, output, 1 bit, a one-clk pulse at the end of a phase.
REQ-017 The block SHALL have port cycle_done, output, 1 bit, a one-clk pulse at the end of phase NUM_PH-1.

Function
REQ-018 The block SHALL implement a three-state FSM: IDLE, RUN, PAUSE.
REQ-019 Input priority SHALL be rst > start > hold > en, evaluated every clk edge.
REQ-020 In any state, start=1 SHALL load phase=0 and count=dur_tbl[0], and go to RUN next cycle; a restart mid-cycle produces no done pulses.
REQ-021 In IDLE without start, count and phase SHALL hold their values; en and hold are ignored.
REQ-022 In RUN, hold=1 SHALL go to PAUSE, with count and phase frozen.
REQ-023 In PAUSE, hold=0 SHALL return to RUN; en is ignored while in PAUSE or when hold=1.
REQ-024 In RUN with en=1, hold=0 and count>0, count SHALL decrement by 1.
REQ-025 In RUN with en=1, hold=0, count==0 and phase<NUM_PH-1, the block SHALL set phase=phase+1 and count=dur_tbl[phase+1].
REQ-026 In RUN with en=1, hold=0, count==0 and phase==NUM_PH-1, the block SHALL, if AUTO_RELOAD=1, set phase=0 and count=dur_tbl[0] and stay in RUN; if AUTO_RELOAD=0, it goes to IDLE with count=0 and phase unchanged.
REQ-027 phase_done SHALL be registered, high for exactly one clk in the cycle following each terminal tick (REQ-025/026).
REQ-028 cycle_done SHALL be registered and coincident with phase_done only for the terminal tick of phase NUM_PH-1.
REQ-029 A duration value D SHALL give D+1 en ticks per phase; D=0 gives a one-tick phase with last asserted immediately after load.
REQ-030 dur_tbl SHALL be sampled only at load instants; changes mid-phase have no effect until the next load.
REQ-031 Arithmetic SHALL be unsigned CNT_W-bit with no underflow: count never wraps below 0.
REQ-032 The block SHALL have no combinational path from inputs to count, phase, phase_done, cycle_done or busy; last and pre_last are decoded from registers only.

Reset
REQ-033 With rst=1 at a clk edge, the block SHALL set state=IDLE, count=0, phase=0, phase_done=0 and cycle_done=0, giving busy=0, last=0 and pre_last=0, regardless of start, hold or en.
REQ-034 Reset asserted mid-RUN or mid-PAUSE SHALL abort immediately with no done pulse; the block remains IDLE after release until start.

Verification
REQ-035 Basic cycle: CNT_W=7, NUM_PH=3, dur={5,2,3}, AUTO_RELOAD=1, start then en every clk -> count 5,4,3,2,1,0,2,1,0,3,2,1,0,5...; phase 0,1,2,0; phase_done after ticks 6, 9 and 13; cycle_done only after tick 13.
REQ-036 Boundary: dur={0,1,0} -> each zero phase lasts 1 tick with last=1 and pre_last=0; the phase with D=1 shows pre_last then last.
REQ-037 Hold: hold=1 for 4 clks at count=3 while en stays 1 -> count stays 3 with busy=1; it resumes at 2 the first en after hold=0.
REQ-038 One-shot: AUTO_RELOAD=0, dur={1,1,1} -> after 6 ticks the block is in IDLE, busy=0, count=0, phase=2, with cycle_done pulsed once; further en leaves everything unchanged.
REQ-039 Restart and reset: start during phase 1 count=1 -> next cycle phase=0, count=dur_tbl[0], no phase_done; rst=1 with start=1 mid-RUN -> IDLE, all outputs 0.
REQ-040 Table sampling: change dur_tbl[1] from 2 to 7 mid-phase 1 -> the current phase still ends after 3 ticks; the next visit to phase 1 loads 7.
